// File: rtl/latch_seq_pkg.sv
// latch_seq_pkg: shared state encoding and hold counter width for the latch bus sequencer
package latch_seq_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    LATCH = 2'd2,
    DRIVE = 2'd3
  } state_t;
  localparam int HOLD_W = 4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester above the last grant
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] j;
  logic          found;
  // scan indices last+1 .. last+NREQ modulo NREQ, keeping the first hit
  always_comb begin
    gnt   = '0;
    idx   = '0;
    j     = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      j = IW'((int'(last) + i) % NREQ);
      if (!found && req[j]) begin
        found  = 1'b1;
        idx    = j;
        gnt[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/latch_bus_sequencer.sv
// latch_bus_sequencer: arbitrates requesters and sequences D/LE/OE_bar onto a shared latch bus
module latch_bus_sequencer
  import latch_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] D_IN,
  output logic [NREQ-1:0]       GNT,
  output logic [WIDTH-1:0]      D,
  output logic                  LE,
  output logic                  OE_bar,
  output logic                  BUSY,
  output logic                  DONE
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_t            state, state_n;
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic [IW-1:0]     last, last_n, win_idx;
  logic [NREQ-1:0]   win, gnt_n;
  logic [WIDTH-1:0]  d_n;
  logic              le_n, oe_n, busy_n, done_n;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (REQ),
    .last(last),
    .gnt (win),
    .idx (win_idx)
  );

  // register state and every output so nothing reaches a pin combinationally
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      last   <= IW'(NREQ - 1);
      GNT    <= '0;
      D      <= '0;
      LE     <= 1'b0;
      OE_bar <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      last   <= last_n;
      GNT    <= gnt_n;
      D      <= d_n;
      LE     <= le_n;
      OE_bar <= oe_n;
      BUSY   <= busy_n;
      DONE   <= done_n;
    end
  end

  // next state and the output values that cycle will present
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    gnt_n   = GNT;
    d_n     = D;
    case (state)
      IDLE: if (|REQ) begin
        state_n = SETUP;
        gnt_n   = win;
        d_n     = D_IN[win_idx*WIDTH +: WIDTH];
        last_n  = win_idx;
      end
      SETUP: state_n = LATCH;
      LATCH: begin
        state_n = DRIVE;
        cnt_n   = HOLD_W'(HOLD_CYCLES - 1);
      end
      DRIVE: if (cnt == '0) begin
        state_n = IDLE;
        gnt_n   = '0;
        d_n     = '0;
      end else begin
        cnt_n = cnt - 1'b1;
      end
    endcase
    le_n   = state_n == LATCH;
    oe_n   = state_n != DRIVE;
    busy_n = state_n != IDLE;
    done_n = (state_n == DRIVE) && (cnt_n == '0);
  end
endmodule

// File: tb/tb_latch_bus_sequencer.sv
// tb_latch_bus_sequencer: directed checks on four sequencers differing only in HOLD_CYCLES
module tb_latch_bus_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] d_in = '0;
  logic [3:0]  gnt [4];
  logic [7:0]  d [4];
  logic        le [4], oe [4], busy [4], done [4];
  int          n_tests = 0, n_fail = 0;
  int          oe_low [4] = '{default: 0};
  int          n_done [4] = '{default: 0};
  int          base_oe [4], base_done [4];
  int          done_mark;
  logic        mon_en = 1'b0;

  always #5 clk = ~clk;

  function automatic int hold_of(int n);
    return n == 0 ? 2 : n == 1 ? 3 : n == 2 ? 1 : 15;
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_dut
    latch_bus_sequencer #(.WIDTH(8), .NREQ(4), .HOLD_CYCLES(hold_of(i))) u_dut (
      .CLK   (clk),
      .RST   (rst),
      .REQ   (req),
      .D_IN  (d_in),
      .GNT   (gnt[i]),
      .D     (d[i]),
      .LE    (le[i]),
      .OE_bar(oe[i]),
      .BUSY  (busy[i]),
      .DONE  (done[i])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    d_in = '0;
    tick();
    rst = 1'b0;
  endtask

  always @(negedge clk) if (mon_en) begin
    for (int k = 0; k < 4; k++) begin
      if (!oe[k]) oe_low[k]++;
      if (done[k]) n_done[k]++;
      check("le_oe_excl", 32'(le[k] && !oe[k]), 32'h0);
      check("gnt_onehot0", 32'($onehot0(gnt[k])), 32'h1);
    end
  end

  initial begin
    do_reset();
    mon_en = 1'b1;
    check("rst_gnt", 32'(gnt[0]), 32'h0);
    check("rst_d", 32'(d[0]), 32'h0);
    check("rst_le", 32'(le[0]), 32'h0);
    check("rst_oe", 32'(oe[0]), 32'h1);
    check("rst_busy", 32'(busy[0]), 32'h0);
    check("rst_done", 32'(done[0]), 32'h0);

    req  = 4'b0001;
    d_in = 32'h0000_00A5;
    tick();
    check("t1_setup_gnt", 32'(gnt[0]), 32'h1);
    check("t1_setup_d", 32'(d[0]), 32'hA5);
    check("t1_setup_le", 32'(le[0]), 32'h0);
    check("t1_setup_oe", 32'(oe[0]), 32'h1);
    check("t1_setup_busy", 32'(busy[0]), 32'h1);
    req = '0;
    tick();
    check("t1_latch_le", 32'(le[0]), 32'h1);
    check("t1_latch_oe", 32'(oe[0]), 32'h1);
    check("t1_latch_d", 32'(d[0]), 32'hA5);
    tick();
    check("t1_drv1_oe", 32'(oe[0]), 32'h0);
    check("t1_drv1_le", 32'(le[0]), 32'h0);
    check("t1_drv1_done", 32'(done[0]), 32'h0);
    tick();
    check("t1_drv2_oe", 32'(oe[0]), 32'h0);
    check("t1_drv2_done", 32'(done[0]), 32'h1);
    tick();
    check("t1_idle_oe", 32'(oe[0]), 32'h1);
    check("t1_idle_done", 32'(done[0]), 32'h0);
    check("t1_idle_busy", 32'(busy[0]), 32'h0);
    check("t1_idle_gnt", 32'(gnt[0]), 32'h0);
    check("t1_idle_d", 32'(d[0]), 32'h0);

    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      tick();
      check("t2_rr_gnt", 32'(gnt[0]), (c % 5 == 4) ? 32'h0 : 32'(1 << ((c / 5) % 4)));
    end

    do_reset();
    req  = 4'b0100;
    d_in = 32'h003C_0000;
    tick();
    check("t3_setup_gnt", 32'(gnt[0]), 32'h4);
    check("t3_setup_d", 32'(d[0]), 32'h3C);
    req = '0;
    tick();
    check("t3_latch_le", 32'(le[0]), 32'h1);
    d_in = 32'h00FF_0000;
    tick();
    check("t3_drv1_d", 32'(d[0]), 32'h3C);
    check("t3_drv1_oe", 32'(oe[0]), 32'h0);
    tick();
    check("t3_drv2_d", 32'(d[0]), 32'h3C);
    check("t3_drv2_gnt", 32'(gnt[0]), 32'h4);
    check("t3_drv2_done", 32'(done[0]), 32'h1);
    tick();
    check("t3_idle_busy", 32'(busy[0]), 32'h0);

    do_reset();
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    tick();
    check("t4_drv1_oe", 32'(oe[1]), 32'h0);
    tick();
    check("t4_drv2_oe", 32'(oe[1]), 32'h0);
    check("t4_drv2_done", 32'(done[1]), 32'h0);
    done_mark = n_done[1];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_abort_oe", 32'(oe[1]), 32'h1);
    check("t4_abort_busy", 32'(busy[1]), 32'h0);
    check("t4_abort_gnt", 32'(gnt[1]), 32'h0);
    check("t4_abort_done", 32'(done[1]), 32'h0);
    req = 4'b0011;
    tick();
    check("t4_regrant_idx0", 32'(gnt[1]), 32'h1);
    check("t4_no_done_pulse", 32'(n_done[1] - done_mark), 32'h0);
    req = '0;
    repeat (6) tick();

    do_reset();
    for (int k = 0; k < 4; k++) begin
      base_oe[k]   = oe_low[k];
      base_done[k] = n_done[k];
    end
    req = 4'b0001;
    tick();
    req = '0;
    repeat (20) tick();
    check("t5_oe_low_h2", 32'(oe_low[0] - base_oe[0]), 32'd2);
    check("t5_oe_low_h3", 32'(oe_low[1] - base_oe[1]), 32'd3);
    check("t5_oe_low_h1", 32'(oe_low[2] - base_oe[2]), 32'd1);
    check("t5_oe_low_h15", 32'(oe_low[3] - base_oe[3]), 32'd15);
    for (int k = 0; k < 4; k++) check("t5_done_once", 32'(n_done[k] - base_done[k]), 32'd1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/latch_bus_sequencer.md
LATCH_BUS_SEQUENCER -- requirements
Module: latch_bus_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: data width of each requester and of the latch bus.
REQ-002 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-003 Parameter HOLD_CYCLES, default 2: cycles OE_bar stays low per transaction; legal range 1..15.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 REQ  input  NREQ  per-requester transfer request, level.
REQ-007 D_IN  input  NREQ*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 GNT  output  NREQ  one-hot grant, all-zero when idle.
REQ-009 D  output  WIDTH  data presented to the latch D inputs.
REQ-010 LE  output  1  latch enable strobe, active-high.
REQ-011 OE_bar  output  1  latch output enable, active-low.
REQ-012 BUSY  output  1  high in every non-IDLE state.
REQ-013 DONE  output  1  one-cycle pulse on the last DRIVE cycle.

Function
REQ-014 The FSM SHALL have four states: IDLE, SETUP, LATCH, DRIVE.
REQ-015 IDLE: GNT=0, LE=0, OE_bar=1, D=0; if any REQ bit is high at an edge, the next state SHALL be SETUP with the arbitration winner granted.
REQ-016 Arbitration SHALL be round-robin: the winner is the lowest requesting index strictly above the last-granted index, wrapping modulo NREQ.
REQ-017 SETUP lasts one cycle: D = winner's D_IN slice; LE=0; OE_bar=1.
REQ-018 LATCH lasts one cycle: D held; LE=1; OE_bar=1.
REQ-019 DRIVE lasts exactly HOLD_CYCLES cycles: LE=0; OE_bar=0; D held.
REQ-020 DONE SHALL be high only in the final DRIVE cycle; the next state is always IDLE, giving one turnaround cycle.
REQ-021 Latency: REQ seen at edge k gives GNT from cycle k+1, LE in cycle k+2, OE_bar low in cycles k+3 .. k+2+HOLD_CYCLES.
REQ-022 GNT SHALL stay constant from SETUP through the last DRIVE cycle; REQ deassertion mid-transaction does not abort or shorten it.
REQ-023 D SHALL be captured into a register in SETUP; D_IN changes after SETUP do not affect D.
REQ-024 LE and OE_bar SHALL never be active in the same cycle.
REQ-025 The last-granted pointer SHALL update when SETUP is entered.
REQ-026 A requester holding REQ high continuously SHALL receive back-to-back transactions only if no other requester is active.
REQ-027 The DRIVE counter SHALL be 4 bits, load HOLD_CYCLES-1 on entry, and exit DRIVE at 0.
REQ-028 All outputs SHALL be registered, with no combinational path from REQ to any output.

Reset
REQ-029 With RST high at an edge, the next cycle SHALL be IDLE with GNT=0, LE=0, OE_bar=1, D=0, BUSY=0, DONE=0.
REQ-030 Reset SHALL set the last-granted pointer to NREQ-1, so index 0 wins first.
REQ-031 Reset in any state, including mid-DRIVE, SHALL abort the transaction immediately with no DONE pulse.

Structure
REQ-032 The state encoding (IDLE=0, SETUP=1, LATCH=2, DRIVE=3) SHALL live in shared package latch_seq_pkg, together with the HOLD counter width constant.
REQ-033 Round-robin selection SHALL be the sub-module rr_arbiter, which is purely combinational.
REQ-034 rr_arbiter inputs: request vector and last-grant index. Outputs: one-hot winner and winner index.

Verification
REQ-035 Reset, then REQ=4'b0001, D_IN slice0=8'hA5 -> GNT=0001 at k+1, LE=1 at k+2, D=A5, OE_bar=0 for 2 cycles, DONE pulses once.
REQ-036 REQ=4'b1111 held continuously -> grant order 0,1,2,3,0, with one IDLE cycle between transactions.
REQ-037 REQ=4'b0100 dropped after 1 cycle, with D_IN changed in LATCH -> full transaction completes with the SETUP-time value on D.
REQ-038 RST asserted during the 2nd DRIVE cycle with HOLD_CYCLES=3 -> next cycle IDLE, OE_bar=1, DONE never high, next grant goes to index 0.
REQ-039 HOLD_CYCLES=1 and 15 -> OE_bar low exactly 1 and 15 cycles respectively.
REQ-040 All runs -> assertion that LE and !OE_bar are never both true and that GNT is always one-hot or zero.
